seg7_scan_ctrl: RTL and testbench

SEG7_SCAN_CTRL -- requirements
Module: seg7_scan_ctrl

---
 rtl/seg7_scan_ctrl.sv | 143 ++++++++++++++
 tb/tb_seg7_scan_ctrl.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/seg7_scan_ctrl.sv
// Time-multiplexed 4-digit 7-segment scan controller with double-buffered digit data.
// Optional leading-zero blanking is enabled by defining SEG7_LEADING_ZERO_BLANK_EN.
module seg7_scan_ctrl #(
    parameter int unsigned DIG_CYC = 50000,
    parameter int unsigned GAP_CYC = 1000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        enable,
    input  logic        load,
    input  logic [15:0] data_in,
    output logic [3:0]  dig_val,
    output logic [3:0]  an,
    output logic [1:0]  dig_idx,
    output logic        frame_done
);

    localparam int unsigned MAX_CYC = (DIG_CYC > GAP_CYC) ? DIG_CYC : GAP_CYC;
    localparam int unsigned CW      = $clog2(MAX_CYC + 1);
    localparam logic [CW-1:0] DIG_LAST = CW'(DIG_CYC - 1);
    localparam logic [CW-1:0] GAP_LAST = CW'((GAP_CYC > 0) ? GAP_CYC - 1 : 0);
    localparam logic [CW-1:0] CNT_MAX  = CW'(MAX_CYC);

    typedef enum logic [1:0] {
        IDLE,
        SHOW,
        GAP
    } state_t;

    state_t        state, state_nxt;
    logic [CW-1:0] cnt, cnt_nxt;
    logic [15:0]   pending, pending_nxt;
    logic [15:0]   active, active_nxt;
    logic [3:0]    an_nxt, dv_nxt;
    logic [1:0]    idx_nxt;
    logic          fd_nxt;
    logic          slot_end;
    logic          show;

    function automatic logic [3:0] nibble(input logic [15:0] v, input logic [1:0] i);
        logic [3:0] n;
        case (i)
            2'd0:    n = v[3:0];
            2'd1:    n = v[7:4];
            2'd2:    n = v[11:8];
            default: n = v[15:12];
        endcase
        return n;
    endfunction

    always_comb begin
        state_nxt   = state;
        cnt_nxt     = (cnt == CNT_MAX) ? cnt : cnt + CW'(1);
        idx_nxt     = dig_idx;
        an_nxt      = an;
        dv_nxt      = dig_val;
        fd_nxt      = 1'b0;
        pending_nxt = load ? data_in : pending;
        active_nxt  = active;
        slot_end    = 1'b0;
        show        = 1'b0;

        if (!enable) begin
            state_nxt = IDLE;
            cnt_nxt   = '0;
            idx_nxt   = '0;
            an_nxt    = '1;
        end else begin
            case (state)
                IDLE: begin
                    state_nxt  = SHOW;
                    cnt_nxt    = '0;
                    idx_nxt    = '0;
                    active_nxt = pending_nxt;
                    show       = 1'b1;
                end
                SHOW: begin
                    if (cnt == DIG_LAST) begin
                        if (GAP_CYC > 0) begin
                            state_nxt = GAP;
                            cnt_nxt   = '0;
                            an_nxt    = '1;
                        end else begin
                            slot_end = 1'b1;
                        end
                    end
                end
                GAP: begin
                    if (cnt == GAP_LAST) slot_end = 1'b1;
                end
                default: state_nxt = IDLE;
            endcase
        end

        // pending_nxt already folds in a coincident load, so a load on the wrap lands directly
        if (slot_end) begin
            state_nxt = SHOW;
            cnt_nxt   = '0;
            idx_nxt   = dig_idx + 2'd1;
            show      = 1'b1;
            if (dig_idx == 2'd3) begin
                fd_nxt     = 1'b1;
                active_nxt = pending_nxt;
            end
        end

        if (show) begin
            an_nxt = ~(4'b0001 << idx_nxt);
            dv_nxt = nibble(active_nxt, idx_nxt);
`ifdef SEG7_LEADING_ZERO_BLANK_EN
            case (idx_nxt)
                2'd1:    if (active_nxt[15:4]  == '0) an_nxt = '1;
                2'd2:    if (active_nxt[15:8]  == '0) an_nxt = '1;
                2'd3:    if (active_nxt[15:12] == '0) an_nxt = '1;
                default: ;
            endcase
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            cnt        <= '0;
            pending    <= '0;
            active     <= '0;
            an         <= '1;
            dig_val    <= '0;
            dig_idx    <= '0;
            frame_done <= 1'b0;
        end else begin
            state      <= state_nxt;
            cnt        <= cnt_nxt;
            pending    <= pending_nxt;
            active     <= active_nxt;
            an         <= an_nxt;
            dig_val    <= dv_nxt;
            dig_idx    <= idx_nxt;
            frame_done <= fd_nxt;
        end
    end

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Directed bench: DUT A (DIG_CYC=4, GAP_CYC=2) via a per-cycle vector table,
// DUT B (DIG_CYC=1, GAP_CYC=0) via a hand-written rotation sequence.
module tb_seg7_scan_ctrl;

`ifdef SEG7_LEADING_ZERO_BLANK_EN
    localparam logic BLANK = 1'b1;
`else
    localparam logic BLANK = 1'b0;
`endif
    localparam logic [3:0] AN1Z = BLANK ? 4'hF : 4'hD;
    localparam logic [3:0] AN2Z = BLANK ? 4'hF : 4'hB;
    localparam logic [3:0] AN3Z = BLANK ? 4'hF : 4'h7;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_a = 1'b1, en_a = 1'b0, ld_a = 1'b0;
    logic [15:0] data_a = '0;
    logic [3:0]  dv_a, an_a;
    logic [1:0]  idx_a;
    logic        fd_a;

    logic        rst_b = 1'b1, en_b = 1'b0, ld_b = 1'b0;
    logic [15:0] data_b = '0;
    logic [3:0]  dv_b, an_b;
    logic [1:0]  idx_b;
    logic        fd_b;

    seg7_scan_ctrl #(.DIG_CYC(4), .GAP_CYC(2)) dut_a (
        .clk(clk), .rst(rst_a), .enable(en_a), .load(ld_a), .data_in(data_a),
        .dig_val(dv_a), .an(an_a), .dig_idx(idx_a), .frame_done(fd_a)
    );

    seg7_scan_ctrl #(.DIG_CYC(1), .GAP_CYC(0)) dut_b (
        .clk(clk), .rst(rst_b), .enable(en_b), .load(ld_b), .data_in(data_b),
        .dig_val(dv_b), .an(an_b), .dig_idx(idx_b), .frame_done(fd_b)
    );

    typedef struct {
        int unsigned rpt;
        logic        rst, en, ld;
        logic [15:0] data;
        logic [3:0]  an, dv;
        logic        dv_chk;
        logic [1:0]  idx;
        logic        fd;
    } vec_t;

    vec_t vecs[$];
    int unsigned n_chk  = 0;
    int unsigned n_fail = 0;

    task automatic add(input int unsigned rpt, input logic r, input logic e, input logic l,
                       input logic [15:0] d, input logic [3:0] a, input logic [3:0] v,
                       input logic vc, input logic [1:0] i, input logic f);
        vec_t t;
        t.rpt = rpt; t.rst = r; t.en = e; t.ld = l; t.data = d;
        t.an = a; t.dv = v; t.dv_chk = vc; t.idx = i; t.fd = f;
        vecs.push_back(t);
    endtask

    task automatic chk(input string name, input int unsigned vi,
                       input logic [15:0] act, input logic [15:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s (vec %0d, t=%0t): got %h, expected %h", name, vi, $time, act, exp);
        end
    endtask

    initial begin
        logic [15:0] bdata;
        logic [3:0]  exp_an [4];

        //   rpt rst en ld data      an    dv    chk idx fd
        add(1, 1, 0, 0, 16'h0000, 4'hF, 4'h0, 1, 0, 0);   // reset state
        add(1, 0, 1, 1, 16'h1234, 4'hE, 4'h4, 1, 0, 0);   // load coincident with IDLE->SHOW
        add(3, 0, 1, 0, 16'h0000, 4'hE, 4'h4, 1, 0, 0);
        add(2, 0, 1, 0, 16'h0000, 4'hF, 4'h4, 1, 0, 0);
        add(4, 0, 1, 0, 16'h0000, 4'hD, 4'h3, 1, 1, 0);
        add(2, 0, 1, 0, 16'h0000, 4'hF, 4'h3, 1, 1, 0);
        add(4, 0, 1, 0, 16'h0000, 4'hB, 4'h2, 1, 2, 0);
        add(2, 0, 1, 0, 16'h0000, 4'hF, 4'h2, 1, 2, 0);
        add(4, 0, 1, 0, 16'h0000, 4'h7, 4'h1, 1, 3, 0);
        add(2, 0, 1, 0, 16'h0000, 4'hF, 4'h1, 1, 3, 0);
        add(1, 0, 1, 0, 16'h0000, 4'hE, 4'h4, 1, 0, 1);   // wrap, 24 cycles after start
        add(3, 0, 1, 0, 16'h0000, 4'hE, 4'h4, 1, 0, 0);
        add(2, 0, 1, 0, 16'h0000, 4'hF, 4'h4, 1, 0, 0);
        add(1, 0, 1, 0, 16'h0000, 4'hD, 4'h3, 1, 1, 0);
        add(1, 0, 1, 1, 16'hABCD, 4'hD, 4'h3, 1, 1, 0);   // load mid-frame: no effect yet
        add(2, 0, 1, 0, 16'h0000, 4'hD, 4'h3, 1, 1, 0);
        add(2, 0, 1, 0, 16'h0000, 4'hF, 4'h3, 1, 1, 0);
        add(4, 0, 1, 0, 16'h0000, 4'hB, 4'h2, 1, 2, 0);
        add(2, 0, 1, 0, 16'h0000, 4'hF, 4'h2, 1, 2, 0);
        add(4, 0, 1, 0, 16'h0000, 4'h7, 4'h1, 1, 3, 0);
        add(2, 0, 1, 0, 16'h0000, 4'hF, 4'h1, 1, 3, 0);
        add(1, 0, 1, 0, 16'h0000, 4'hE, 4'hD, 1, 0, 1);   // new frame uses ABCD
        add(3, 0, 1, 0, 16'h0000, 4'hE, 4'hD, 1, 0, 0);
        add(2, 0, 1, 0, 16'h0000, 4'hF, 4'hD, 1, 0, 0);
        add(4, 0, 1, 0, 16'h0000, 4'hD, 4'hC, 1, 1, 0);
        add(2, 0, 1, 0, 16'h0000, 4'hF, 4'hC, 1, 1, 0);
        add(2, 0, 1, 0, 16'h0000, 4'hB, 4'hB, 1, 2, 0);
        add(3, 0, 0, 0, 16'h0000, 4'hF, 4'h0, 0, 0, 0);   // enable dropped mid-SHOW digit 2
        add(1, 0, 1, 0, 16'h0000, 4'hE, 4'hD, 1, 0, 0);   // re-enable shows retained data
        add(3, 0, 1, 0, 16'h0000, 4'hE, 4'hD, 1, 0, 0);
        add(1, 0, 1, 0, 16'h0000, 4'hF, 4'hD, 1, 0, 0);
        add(1, 1, 1, 1, 16'h5555, 4'hF, 4'h0, 1, 0, 0);   // rst mid-GAP dominates enable/load
        add(1, 0, 1, 0, 16'h0000, 4'hE, 4'h0, 1, 0, 0);
        add(3, 0, 1, 0, 16'h0000, 4'hE, 4'h0, 1, 0, 0);
        add(2, 0, 1, 0, 16'h0000, 4'hF, 4'h0, 1, 0, 0);
        add(1, 1, 0, 0, 16'h0000, 4'hF, 4'h0, 1, 0, 0);
        add(1, 0, 1, 1, 16'h0050, 4'hE, 4'h0, 1, 0, 0);   // leading-zero frame
        add(3, 0, 1, 0, 16'h0000, 4'hE, 4'h0, 1, 0, 0);
        add(2, 0, 1, 0, 16'h0000, 4'hF, 4'h0, 1, 0, 0);
        add(4, 0, 1, 0, 16'h0000, 4'hD, 4'h5, 1, 1, 0);
        add(2, 0, 1, 0, 16'h0000, 4'hF, 4'h5, 1, 1, 0);
        add(4, 0, 1, 0, 16'h0000, AN2Z, 4'h0, 1, 2, 0);
        add(2, 0, 1, 0, 16'h0000, 4'hF, 4'h0, 1, 2, 0);
        add(4, 0, 1, 0, 16'h0000, AN3Z, 4'h0, 1, 3, 0);
        add(2, 0, 1, 0, 16'h0000, 4'hF, 4'h0, 1, 3, 0);
        add(1, 0, 1, 1, 16'h0000, 4'hE, 4'h0, 1, 0, 1);   // load coincident with wrap
        add(3, 0, 1, 0, 16'h0000, 4'hE, 4'h0, 1, 0, 0);
        add(2, 0, 1, 0, 16'h0000, 4'hF, 4'h0, 1, 0, 0);
        add(4, 0, 1, 0, 16'h0000, AN1Z, 4'h0, 1, 1, 0);
        add(2, 0, 1, 0, 16'h0000, 4'hF, 4'h0, 1, 1, 0);
        add(4, 0, 1, 0, 16'h0000, AN2Z, 4'h0, 1, 2, 0);
        add(2, 0, 1, 0, 16'h0000, 4'hF, 4'h0, 1, 2, 0);
        add(4, 0, 1, 0, 16'h0000, AN3Z, 4'h0, 1, 3, 0);
        add(2, 0, 1, 0, 16'h0000, 4'hF, 4'h0, 1, 3, 0);
        add(1, 0, 1, 0, 16'h0000, 4'hE, 4'h0, 1, 0, 1);

        @(negedge clk);
        for (int unsigned vi = 0; vi < vecs.size(); vi++) begin
            for (int unsigned k = 0; k < vecs[vi].rpt; k++) begin
                rst_a  = vecs[vi].rst;
                en_a   = vecs[vi].en;
                ld_a   = vecs[vi].ld;
                data_a = vecs[vi].data;
                @(posedge clk);
                #1;
                chk("an", vi, 16'(an_a), 16'(vecs[vi].an));
                if (vecs[vi].dv_chk) chk("dig_val", vi, 16'(dv_a), 16'(vecs[vi].dv));
                chk("dig_idx", vi, 16'(idx_a), 16'(vecs[vi].idx));
                chk("frame_done", vi, 16'(fd_a), 16'(vecs[vi].fd));
            end
        end

        // DUT B: one-cycle slots, no gap
        exp_an[0] = 4'hE; exp_an[1] = 4'hD; exp_an[2] = 4'hB; exp_an[3] = 4'h7;
        bdata = 16'h1234;
        rst_b = 1'b1; en_b = 1'b0;
        @(posedge clk); #1;
        chk("b_reset_an", 0, 16'(an_b), 16'hF);
        rst_b = 1'b0; en_b = 1'b1; ld_b = 1'b1; data_b = bdata;
        for (int unsigned i = 0; i < 12; i++) begin
            @(posedge clk); #1;
            ld_b = 1'b0;
            chk("b_an", i, 16'(an_b), 16'(exp_an[i % 4]));
            chk("b_dig_idx", i, 16'(idx_b), 16'(i % 4));
            chk("b_dig_val", i, 16'(dv_b), 16'(bdata[4*(i%4) +: 4]));
            chk("b_frame_done", i, 16'(fd_b), 16'((i % 4 == 0) && (i > 0)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
